ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Host-side initiator for the shared 32-bit scratch-RAM access port (ram_sel/ram_waddr/ram_raddr/ram_wen/ram_ren/ram_wdata/ram_rdata) that the RAM multiplexer decodes.
- Accepts burst commands and streams write data in or read data out over valid/ready handshakes.
- Enforces the port's rules: even/odd word pairing for 64-bit targets, one-cycle read latency, and ram_sel held stable until the last read word has returned.

Parameters:
- RD_FIFO_DEPTH, 4, read-return FIFO entries (power of 2, ≥2); bounds outstanding reads.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_sel  in  8  target select: 0x00-0x3F bn, 0x40-0x7F conv, 0x80 in, 0x81 out, 0x82 ir
- cmd_addr  in  11  start word address
- cmd_len  in  11  word count minus 1 (1..2048 words)
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word consumed
- wr_data  in  32  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  read word taken
- rd_data  out  32  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on rejected command
- stat_words  out  32  optional statistics (see Optional Feature)
- ram_sel  out  8  target select to mux
- ram_waddr  out  11  write word address
- ram_raddr  out  11  read word address
- ram_wen  out  1  write strobe
- ram_ren  out  1  read strobe
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid the cycle after ram_ren

Behaviour:
- Reset (rstn low at clk edge):
  - state IDLE; all outputs 0 except ram_sel = 0xFF (unmapped, rdata reads 0).
  - FIFO emptied, counters cleared; an in-flight burst is abandoned and no done pulse is issued.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready = 1; ram_sel = 0xFF.
- Command check, on cmd_valid & cmd_ready:
  - Wide target (cmd_sel 0x40-0x81): cmd_addr[0] must be 0 and cmd_len[0] must be 1 (even word count).
  - Target must be ≤ 0x82.
  - {1'b0,cmd_addr} + cmd_len must be ≤ 2047.
  - Any violation: err pulses next cycle, stay IDLE, no RAM strobes.
  - Otherwise latch sel/addr/len, drive ram_sel next cycle, busy = 1, go to WRITE or READ.
- WRITE:
  - wr_ready = 1.
  - Each cycle with wr_valid: ram_wen = 1, ram_waddr = current address, ram_wdata = wr_data (all registered, asserted the cycle after acceptance); address +1.
  - A gap between an even and an odd word is legal (the mux holds the even word).
  - After the last word is accepted: done pulses in the cycle its ram_wen is asserted, then IDLE.
- READ:
  - ram_ren = 1 with ram_raddr when (FIFO count + outstanding) < RD_FIFO_DEPTH; outstanding is at most 1.
  - ram_rdata is captured into the FIFO the cycle after each ram_ren.
  - After the last ram_ren, go to DRAIN.
- DRAIN:
  - ram_sel is held until the final capture.
  - done pulses when the last word leaves the FIFO (rd_valid & rd_ready), then IDLE.
- Read stream:
  - rd_valid = FIFO not empty; rd_data = FIFO head.
  - Simultaneous capture and pop allowed at full.
  - No word is dropped or duplicated under any rd_ready pattern.
- Address never wraps (guaranteed by the command check). Length 0 means 1 word.
- busy = 1 in WRITE, READ, and DRAIN.

Optional Feature:
- RAM_LOADER_STATS_EN defined:
  - stat_words counts every ram_wen and every FIFO pop.
  - Saturates at 0xFFFFFFFF; cleared only by reset.
- Not defined: stat_words is tied to 0 and no counter logic is present.

Test Plan:
- Write sel 0x82, addr 0, len 3, data 0x11..0x44 → ram_wen ×4 on addresses 0..3, done once, then read back returns 0x11, 0x22, 0x33, 0x44.
- Write sel 0x80, addr 2, len 3, with wr_valid low for 3 cycles between words 0 and 1 → four strobes on addresses 2..5 with matching data, ram_sel = 0x80 throughout.
- Read sel 0x41, addr 0, len 7, rd_ready toggling 1 of 3 cycles → 8 words in order, ram_ren never leaves > RD_FIFO_DEPTH words outstanding, ram_sel = 0x41 until the last capture.
- Reject cases, each → err pulse, no strobes, cmd_ready still 1:
  - sel 0x81 with addr 1;
  - sel 0x40 with len 2;
  - sel 0x90;
  - addr 2040 with len 10.
- Assert rstn low mid-read (word 3 of 8) → next cycle all strobes 0, ram_sel = 0xFF, rd_valid 0, no done; a new command is accepted afterwards.
- With RAM_LOADER_STATS_EN: write 4 words then read 4 words → stat_words = 8; without the macro → stat_words = 0.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: burst initiator for the shared 32-bit scratch-RAM port.
// Define RAM_LOADER_STATS_EN to enable the saturating stat_words counter.
module ram_loader #(
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_sel,
  input  logic [10:0] cmd_addr,
  input  logic [10:0] cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] stat_words,
  output logic [7:0]  ram_sel,
  output logic [10:0] ram_waddr,
  output logic [10:0] ram_raddr,
  output logic        ram_wen,
  output logic        ram_ren,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int AW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  sel_q, sel_d;
  logic [10:0] addr_q, addr_d;
  logic [10:0] rem_q, rem_d;
  logic        wen_q, wen_d;
  logic [10:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        out_q, out_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] mem_q [RD_FIFO_DEPTH];

  logic        accept;
  logic        wide;
  logic        bad;
  logic [11:0] span;
  logic [CW:0] fill;
  logic        ren;
  logic        push;
  logic        pop;
  logic        last_pop;

  // command legality and read-issue flow control
  always_comb begin
    accept = cmd_valid && cmd_ready;
    wide = (cmd_sel >= 8'h40) && (cmd_sel <= 8'h81);
    span = {1'b0, cmd_addr} + {1'b0, cmd_len};
    bad = (cmd_sel > 8'h82)
       || (wide && (cmd_addr[0] || !cmd_len[0]))
       || (span > 12'd2047);
    fill = {1'b0, cnt_q} + {{CW{1'b0}}, out_q};
    ren = (state_q == READ) && (fill < (CW+1)'(RD_FIFO_DEPTH));
    push = out_q;
    pop = rd_valid && rd_ready;
    last_pop = (state_q == DRAIN) && pop
            && (cnt_q == CW'(1)) && !out_q;
  end

  // burst sequencing: next state, address walk, write strobes
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    addr_d = addr_q;
    rem_d = rem_q;
    wen_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d = 1'b0;
    err_d = 1'b0;
    out_d = ren;
    unique case (state_q)
      IDLE: begin
        sel_d = 8'hFF;
        if (accept) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            sel_d = cmd_sel;
            addr_d = cmd_addr;
            rem_d = cmd_len;
            state_d = cmd_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (wr_valid) begin
          wen_d = 1'b1;
          waddr_d = addr_q;
          wdata_d = wr_data;
          addr_d = addr_q + 11'd1;
          rem_d = rem_q - 11'd1;
          if (rem_q == 11'd0) begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (ren) begin
          addr_d = addr_q + 11'd1;
          rem_d = rem_q - 11'd1;
          if (rem_q == 11'd0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
          sel_d = 8'hFF;
        end
      end
    endcase
  end

  // read-return FIFO pointer and occupancy update
  always_comb begin
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // control and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q <= 8'hFF;
      addr_q <= '0;
      rem_q <= '0;
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      out_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
      err_q <= err_d;
      out_q <= out_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage captures ram_rdata the cycle after each read strobe
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= ram_rdata;
  end

  assign cmd_ready = rstn && (state_q == IDLE);
  assign wr_ready = (state_q == WRITE);
  assign busy = (state_q != IDLE);
  assign done = done_q || last_pop;
  assign err = err_q;
  assign rd_valid = (cnt_q != '0);
  assign rd_data = mem_q[rp_q];
  assign ram_sel = sel_q;
  assign ram_wen = wen_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign ram_ren = ren;
  assign ram_raddr = ren ? addr_q : '0;

`ifdef RAM_LOADER_STATS_EN
  logic [31:0] stat_q, stat_d;
  logic [32:0] stat_sum;

  // saturating count of write strobes and FIFO pops
  always_comb begin
    stat_sum = {1'b0, stat_q} + 33'(wen_q) + 33'(pop);
    stat_d = stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
  end

  // statistics register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) stat_q <= '0;
    else stat_q <= stat_d;
  end

  assign stat_words = stat_q;
`else
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader.
// Includes a registered RAM model keyed by {sel, addr}.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_sel;
  logic [10:0] cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [31:0] stat_words;
  logic [7:0]  ram_sel;
  logic [10:0] ram_waddr, ram_raddr;
  logic        ram_wen, ram_ren;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_loader #(.RD_FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .stat_words(stat_words),
    .ram_sel(ram_sel), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wen(ram_wen),
    .ram_ren(ram_ren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  logic [31:0] ram_m [logic [18:0]];

  always @(posedge clk) begin
    if (ram_wen) ram_m[{ram_sel, ram_waddr}] = ram_wdata;
    if (ram_ren && ram_m.exists({ram_sel, ram_raddr}))
      ram_rdata <= ram_m[{ram_sel, ram_raddr}];
    else
      ram_rdata <= 32'h0;
  end

  typedef struct packed {
    logic [7:0]  sel;
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_exp[$], wr_obs[$];
  logic [31:0] rd_exp[$], rd_obs[$];
  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, strobe_cnt = 0;
  int pop_cnt = 0, ren_cnt = 0, max_infl = 0, sel_bad = 0;
  logic [7:0] exp_sel = 8'hFF;

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (ram_wen) wr_obs.push_back({ram_sel, ram_waddr, ram_wdata});
      if (rd_valid && rd_ready) begin
        rd_obs.push_back(rd_data);
        pop_cnt++;
      end
      if (ram_ren) ren_cnt++;
      if (ram_wen || ram_ren) strobe_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((busy || ram_wen || ram_ren) && ram_sel !== exp_sel) sel_bad++;
      if (ren_cnt - pop_cnt > max_infl) max_infl = ren_cnt - pop_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    wr_obs.delete();
    rd_obs.delete();
    wr_exp.delete();
    rd_exp.delete();
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] s,
                          input logic [10:0] a, input logic [10:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_sel = s;
    cmd_addr = a;
    cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed_write(input logic [7:0] s, input logic [10:0] a,
                            input int n, input logic [31:0] base,
                            input logic [31:0] step, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0;
          tick();
        end
      end
      wr_valid = 1'b1;
      wr_data = base + step * i;
      wr_exp.push_back({s, a + 11'(i), base + step * i});
      for (int t = 0; t < 50 && !wr_ready; t++) tick();
      n_checks++;
      if (wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL wr_ready_wait: got %b, want 1", wr_ready);
      end
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int d0, input int bound);
    for (int t = 0; t < bound && done_cnt == d0; t++) begin
      rd_ready = 1'b1;
      tick();
    end
    tick();
    rd_ready = 1'b0;
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d, want 1", nm, done_cnt - d0);
    end
  endtask

  task automatic check_writes(input string nm);
    wr_t e, o;
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front();
      n_checks++;
      if (wr_obs.size() == 0) begin
        n_fail++;
        $display("FAIL %s_wr: got none, want %h", nm, e);
      end else begin
        o = wr_obs.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s_wr: got %h, want %h", nm, o, e);
        end
      end
    end
    n_checks++;
    if (wr_obs.size() != 0) begin
      n_fail++;
      $display("FAIL %s_wr_extra: got %0d extra, want 0", nm, wr_obs.size());
    end
    wr_obs.delete();
  endtask

  task automatic check_reads(input string nm);
    logic [31:0] e, o;
    while (rd_exp.size() > 0) begin
      e = rd_exp.pop_front();
      n_checks++;
      if (rd_obs.size() == 0) begin
        n_fail++;
        $display("FAIL %s_rd: got none, want %h", nm, e);
      end else begin
        o = rd_obs.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s_rd: got %h, want %h", nm, o, e);
        end
      end
    end
    n_checks++;
    if (rd_obs.size() != 0) begin
      n_fail++;
      $display("FAIL %s_rd_extra: got %0d extra, want 0", nm, rd_obs.size());
    end
    rd_obs.delete();
  endtask

  task automatic read_throttled(input string nm, input int d0, input int bound);
    for (int t = 0; t < bound && done_cnt == d0; t++) begin
      rd_ready = (t % 3 == 0);
      tick();
    end
    tick();
    rd_ready = 1'b0;
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d, want 1", nm, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({cmd_ready, wr_ready, rd_valid, busy, done, err, ram_wen, ram_ren}
        !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, want 00000000",
               {cmd_ready, wr_ready, rd_valid, busy, done, err, ram_wen, ram_ren});
    end
    n_checks++;
    if (ram_sel !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_sel: got %h, want ff", ram_sel);
    end
    n_checks++;
    if (stat_words !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_stat: got %h, want 0", stat_words);
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
    end
  endtask

  task automatic test_write_readback();
    int d0;
    exp_sel = 8'h82;
    sel_bad = 0;
    d0 = done_cnt;
    send_cmd(1'b1, 8'h82, 11'd0, 11'd3);
    feed_write(8'h82, 11'd0, 4, 32'h11, 32'h11, 0);
    wait_done("wr1", d0, 20);
    check_writes("wr1");
    for (int i = 0; i < 4; i++) rd_exp.push_back(32'h11 * (i + 1));
    d0 = done_cnt;
    send_cmd(1'b0, 8'h82, 11'd0, 11'd3);
    wait_done("rb1", d0, 40);
    check_reads("rb1");
    n_checks++;
    if (sel_bad != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr1_sel_busy: got sel_bad=%0d busy=%b, want 0 0",
               sel_bad, busy);
    end
  endtask

  task automatic test_write_gap();
    int d0;
    exp_sel = 8'h80;
    sel_bad = 0;
    d0 = done_cnt;
    send_cmd(1'b1, 8'h80, 11'd2, 11'd3);
    feed_write(8'h80, 11'd2, 4, 32'hCAFE_0000, 32'h1, 3);
    wait_done("gap", d0, 20);
    check_writes("gap");
    n_checks++;
    if (sel_bad != 0) begin
      n_fail++;
      $display("FAIL gap_sel: got %0d bad cycles, want 0", sel_bad);
    end
  endtask

  task automatic test_read_throttle();
    int d0;
    for (int i = 0; i < 8; i++) begin
      ram_m[{8'h41, 11'(i)}] = 32'hA000_0000 + 32'h1111 * i;
      rd_exp.push_back(32'hA000_0000 + 32'h1111 * i);
    end
    exp_sel = 8'h41;
    sel_bad = 0;
    ren_cnt = 0;
    pop_cnt = 0;
    max_infl = 0;
    d0 = done_cnt;
    send_cmd(1'b0, 8'h41, 11'd0, 11'd7);
    read_throttled("thr", d0, 200);
    check_reads("thr");
    n_checks++;
    if (max_infl > 4 || ren_cnt != 8) begin
      n_fail++;
      $display("FAIL thr_outstanding: got max=%0d ren=%0d, want <=4 8",
               max_infl, ren_cnt);
    end
    n_checks++;
    if (sel_bad != 0) begin
      n_fail++;
      $display("FAIL thr_sel: got %0d bad cycles, want 0", sel_bad);
    end
  endtask

  task automatic test_reject();
    logic [7:0]  ts [4] = '{8'h81, 8'h40, 8'h90, 8'h82};
    logic [10:0] ta [4] = '{11'd1, 11'd0, 11'd0, 11'd2040};
    logic [10:0] tl [4] = '{11'd1, 11'd2, 11'd0, 11'd10};
    int s0, e0;
    exp_sel = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      send_cmd(k[0], ts[k], ta[k], tl[k]);
      n_checks++;
      if ({err, busy, cmd_ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL rej%0d_flags: got err/busy/rdy=%b, want 101",
                 k, {err, busy, cmd_ready});
      end
      tick();
      tick();
      n_checks++;
      if (strobe_cnt != s0 || err_cnt - e0 != 1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL rej%0d_pulse: got strobes=%0d errs=%0d, want 0 1",
                 k, strobe_cnt - s0, err_cnt - e0);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int d0;
    exp_sel = 8'h41;
    pop_cnt = 0;
    rd_obs.delete();
    d0 = done_cnt;
    send_cmd(1'b0, 8'h41, 11'd0, 11'd7);
    rd_ready = 1'b1;
    for (int t = 0; t < 50 && pop_cnt < 3; t++) tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_obs.size() <= i || rd_obs[i] !== 32'hA000_0000 + 32'h1111 * i) begin
        n_fail++;
        $display("FAIL mid_word%0d: got %h, want %h", i,
                 rd_obs.size() > i ? rd_obs[i] : 32'hx,
                 32'hA000_0000 + 32'h1111 * i);
      end
    end
    rstn = 1'b0;
    tick();
    n_checks++;
    if ({ram_wen, ram_ren, rd_valid, busy, done} !== 5'b0 || ram_sel !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_reset_out: got flags=%b sel=%h, want 00000 ff",
               {ram_wen, ram_ren, rd_valid, busy, done}, ram_sel);
    end
    rstn = 1'b1;
    rd_ready = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    n_checks++;
    if (done_cnt != d0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_done: got done=%0d rd_valid=%b, want 0 0",
               done_cnt - d0, rd_valid);
    end
    rd_obs.delete();
    wr_obs.delete();
    exp_sel = 8'h82;
    sel_bad = 0;
    d0 = done_cnt;
    send_cmd(1'b1, 8'h82, 11'd10, 11'd0);
    feed_write(8'h82, 11'd10, 1, 32'h5A5A_0001, 32'h0, 0);
    wait_done("post", d0, 20);
    check_writes("post");
  endtask

  task automatic test_stats();
    int d0;
    do_reset();
    exp_sel = 8'h82;
    d0 = done_cnt;
    send_cmd(1'b1, 8'h82, 11'd100, 11'd3);
    feed_write(8'h82, 11'd100, 4, 32'h7000_0000, 32'h3, 0);
    wait_done("st_wr", d0, 20);
    check_writes("st_wr");
    for (int i = 0; i < 4; i++) rd_exp.push_back(32'h7000_0000 + 32'h3 * i);
    d0 = done_cnt;
    send_cmd(1'b0, 8'h82, 11'd100, 11'd3);
    wait_done("st_rd", d0, 40);
    check_reads("st_rd");
    n_checks++;
`ifdef RAM_LOADER_STATS_EN
    if (stat_words !== 32'd8) begin
      n_fail++;
      $display("FAIL stat_words: got %0d, want 8", stat_words);
    end
`else
    if (stat_words !== 32'd0) begin
      n_fail++;
      $display("FAIL stat_words: got %0d, want 0", stat_words);
    end
`endif
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_sel = 8'h00;
    cmd_addr = 11'd0;
    cmd_len = 11'd0;
    wr_valid = 1'b0;
    wr_data = 32'h0;
    rd_ready = 1'b0;
    test_reset();
    test_write_readback();
    test_write_gap();
    test_read_throttle();
    test_reject();
    test_reset_mid_read();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
